grf_wb: RTL

- Writeback-stage consumer of the MEM/WB pipeline register outputs (W_instr, W_dm, W_ALUresult, W_pc).
- Decodes the W-stage instruction into write address, write data and write enable, and commits the result to the 32x32 general register file (GRF).
- Serves the D-stage read ports, with internal write-to-read bypass.
- Exports the W-stage write triple for the forwarding unit, plus a retired-instruction counter.

---
 rtl/mips_defs.sv | 28 ++
 rtl/wb_decode.sv | 75 +++++++
 rtl/grf_wb.sv | 90 +++++++++
 3 files changed

// File: rtl/mips_defs.sv
// Shared MIPS encoding constants and the writeback source select.
// Also used by the D-stage controller and the forwarding unit.
package mips_defs;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_JAL     = 6'b000011;

    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [2:0] {
        WbNone,
        WbRdAlu,
        WbRtAlu,
        WbRtDm,
        WbLink
    } wb_sel_e;

endpackage

// File: rtl/wb_decode.sv
// Combinational W-stage decode: instruction -> register write address, data and enable.
// Non-writing or unrecognised encodings yield wa = 0, wd = 0, we = 0.
module wb_decode
    import mips_defs::*;
#(
    parameter int unsigned PC_LINK_OFS = 8
) (
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] dm_i,
    input  logic [31:0] alu_result_i,
    output logic [4:0]  wa_o,
    output logic [31:0] wd_o,
    output logic        we_o
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    wb_sel_e     sel;
    logic [4:0]  wa_raw;
    logic [31:0] wd_raw;

    assign opcode = instr_i[31:26];
    assign funct  = instr_i[5:0];

    // rs and shamt never select a writeback target
    logic unused_fields;
    assign unused_fields = ^{instr_i[25:21], instr_i[10:6]};

    always_comb begin
        sel = WbNone;
        case (opcode)
            OP_SPECIAL: begin
                if (funct == FUNCT_ADDU || funct == FUNCT_SUBU) begin
                    sel = WbRdAlu;
                end
            end
            OP_ORI, OP_LUI: sel = WbRtAlu;
            OP_LW:          sel = WbRtDm;
            OP_JAL:         sel = WbLink;
            default:        sel = WbNone;
        endcase
    end

    always_comb begin
        wa_raw = REG_ZERO;
        wd_raw = '0;
        case (sel)
            WbRdAlu: begin
                wa_raw = instr_i[15:11];
                wd_raw = alu_result_i;
            end
            WbRtAlu: begin
                wa_raw = instr_i[20:16];
                wd_raw = alu_result_i;
            end
            WbRtDm: begin
                wa_raw = instr_i[20:16];
                wd_raw = dm_i;
            end
            WbLink: begin
                wa_raw = REG_RA;
                wd_raw = pc_i + 32'(PC_LINK_OFS);
            end
            default: begin
                wa_raw = REG_ZERO;
                wd_raw = '0;
            end
        endcase
        we_o = (wa_raw != REG_ZERO);
        wa_o = we_o ? wa_raw : REG_ZERO;
        wd_o = we_o ? wd_raw : '0;
    end

endmodule

// File: rtl/grf_wb.sv
// Writeback stage: 32x32 register file with write-to-read bypass and retire counter.
// Optional macro GRF_DISPLAY_EN prints one trace line per committed register write.
module grf_wb
    import mips_defs::*;
#(
    parameter int unsigned NREG        = 32,
    parameter int unsigned PC_LINK_OFS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] W_instr,
    input  logic [31:0] W_dm,
    input  logic [31:0] W_ALUresult,
    input  logic [31:0] W_pc,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    output logic [31:0] D_rs_data,
    output logic [31:0] D_rt_data,
    output logic [4:0]  W_wa,
    output logic [31:0] W_wd,
    output logic        W_we,
    output logic [31:0] retire_count
);

    logic [31:0] grf_q [NREG];
    logic [31:0] grf_d [NREG];
    logic [31:0] retire_count_q;
    logic [31:0] retire_count_d;
    logic        dec_we;

    wb_decode #(
        .PC_LINK_OFS (PC_LINK_OFS)
    ) u_wb_decode (
        .instr_i      (W_instr),
        .pc_i         (W_pc),
        .dm_i         (W_dm),
        .alu_result_i (W_ALUresult),
        .wa_o         (W_wa),
        .wd_o         (W_wd),
        .we_o         (dec_we)
    );

    // Gating with reset also disables the bypass while reset is held
    assign W_we = dec_we && !reset;

    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            grf_d[i] = reset ? '0 : grf_q[i];
        end
        if (W_we) begin
            grf_d[W_wa] = W_wd;
        end
    end

    always_comb begin
        retire_count_d = retire_count_q;
        if (reset) begin
            retire_count_d = '0;
        end else if (W_instr != '0) begin
            retire_count_d = retire_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        grf_q          <= grf_d;
        retire_count_q <= retire_count_d;
    end

    always_comb begin
        D_rs_data = '0;
        if (D_rs_addr != REG_ZERO) begin
            D_rs_data = (W_we && D_rs_addr == W_wa) ? W_wd : grf_q[D_rs_addr];
        end
        D_rt_data = '0;
        if (D_rt_addr != REG_ZERO) begin
            D_rt_data = (W_we && D_rt_addr == W_wa) ? W_wd : grf_q[D_rt_addr];
        end
    end

    assign retire_count = retire_count_q;

`ifdef GRF_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (W_we) begin
            $display("@%h: $%d <= %h", W_pc, W_wa, W_wd);
        end
    end
`endif

endmodule
